// File: rtl/channel_write_arbiter.sv
// channel_write_arbiter: round-robin arbiter sharing one channel write port between NUM_REQ producers
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   p_valid/p_last    per-producer word valid / end-of-burst marker
//   p_data            packed producer words, producer i at [i*WIDTH +: WIDTH]
//   p_ready           per-producer accept strobe
//   ch_in_data        channel write data
//   ch_write_valid    channel write strobe
//   ch_read_valid     read side is owned by the consumer, held 0
//   ch_rst            channel reset, follows rst combinationally
//   ch_write_ready    channel can accept a word
//   busy              a grant is active
//   grant_id          current owner in XFER, last owner in IDLE
module channel_write_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int BURST   = 4,
  localparam int ID_W   = $clog2(NUM_REQ),
  localparam int CNT_W  = $clog2(BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       p_valid,
  input  logic [NUM_REQ-1:0]       p_last,
  input  logic [NUM_REQ*WIDTH-1:0] p_data,
  output logic [NUM_REQ-1:0]       p_ready,
  output logic [WIDTH-1:0]         ch_in_data,
  output logic                     ch_write_valid,
  output logic                     ch_read_valid,
  output logic                     ch_rst,
  input  logic                     ch_write_ready,
  output logic                     busy,
  output logic [ID_W-1:0]          grant_id
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_XFER = 1'b1;
  logic [0:0]       r_state;
  logic [ID_W-1:0]  r_owner;
  logic [ID_W-1:0]  r_last_owner;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_words [NUM_REQ];
  logic [ID_W-1:0]  w_next;
  logic [ID_W-1:0]  w_idx;
  logic             w_found;
  logic             w_xfer_st;
  logic             w_xfer;
  logic             w_release;
  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_words[g] = p_data[g*WIDTH +: WIDTH];
    end
  endgenerate
  // first requester after the previous owner, wrapping modulo NUM_REQ
  always_comb begin
    w_next  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_last_owner) + k) % NUM_REQ);
      if (!w_found && p_valid[w_idx]) begin
        w_found = 1'b1;
        w_next  = w_idx;
      end
    end
  end
  assign w_xfer_st      = (r_state == S_XFER) && !rst;
  assign w_xfer         = w_xfer_st && p_valid[r_owner] && ch_write_ready;
  assign w_release      = !p_valid[r_owner] || (w_xfer && (p_last[r_owner] || r_cnt == CNT_W'(BURST - 1)));
  assign ch_write_valid = w_xfer;
  assign p_ready        = w_xfer ? (NUM_REQ'(1) << r_owner) : '0;
  assign ch_in_data     = w_xfer_st ? w_words[r_owner] : '0;
  assign busy           = w_xfer_st;
  assign grant_id       = rst ? '0 : r_owner;
  assign ch_read_valid  = 1'b0;
  assign ch_rst         = rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_last_owner <= ID_W'(NUM_REQ - 1);
      r_cnt        <= '0;
    end else if (r_state == S_IDLE) begin
      if (|p_valid) begin
        r_owner <= w_next;
        r_cnt   <= '0;
        r_state <= S_XFER;
      end
    end else if (w_release) begin
      r_last_owner <= r_owner;
      r_state      <= S_IDLE;
    end else if (w_xfer) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule
